// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - key codes, scan codes and decoder state types for the PS/2 key decoder
package ps2_key_decoder_pkg;

    typedef enum logic [3:0] {
        key_relesed = 4'd0,
        key_A       = 4'd1,
        key_S       = 4'd2,
        key_W       = 4'd3,
        key_D       = 4'd4,
        key_1       = 4'd5,
        key_2       = 4'd6,
        key_3       = 4'd7,
        key_4       = 4'd8,
        key_esc     = 4'd9
    } key_t;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BREAK,
        ST_EXT_BREAK
    } dec_state_t;

    // Unmapped scan codes come back as key_relesed, which the decoder treats as "ignore".
    function automatic key_t sc_to_key(input logic [7:0] sc);
        key_t k;
        case (sc)
            SC_A:    k = key_A;
            SC_S:    k = key_S;
            SC_W:    k = key_W;
            SC_D:    k = key_D;
            SC_1:    k = key_1;
            SC_2:    k = key_2;
            SC_3:    k = key_3;
            SC_4:    k = key_4;
            SC_ESC:  k = key_esc;
            default: k = key_relesed;
        endcase
        return k;
    endfunction

    function automatic logic [7:0] key_to_sc(input key_t k);
        logic [7:0] sc;
        case (k)
            key_A:   sc = SC_A;
            key_S:   sc = SC_S;
            key_W:   sc = SC_W;
            key_D:   sc = SC_D;
            key_1:   sc = SC_1;
            key_2:   sc = SC_2;
            key_3:   sc = SC_3;
            key_4:   sc = SC_4;
            key_esc: sc = SC_ESC;
            default: sc = 8'h00;
        endcase
        return sc;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 pins and decoded key outputs
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key_code;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_code,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_code,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// rtl/ps2_key_decoder_rx.sv - PS/2 frame receiver: sync, glitch filter, shift, parity and timeout
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_err_q, rx_err_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        fcnt_d     = '0;
        fall_d     = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        // Filtered level only follows the synced pin after FILTER_LEN disagreeing samples in a row.
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        if (fall_q) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                // shift_q: [0]=start, [8:1]=data, [9]=parity; the stop bit is on the pin now.
                if (shift_q[0] || !(^shift_q[9:1]) || !dat_sync_q[1]) begin
                    rx_err_d = 1'b1;
                end else begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = shift_q[8:1];
                end
            end else begin
                shift_d   = {dat_sync_q[1], shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC)) begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                rx_err_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            fall_q     <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            fall_q     <= fall_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code set 2 to game key code decoder
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic               clk,
    input  logic               rst_n,
    ps2_key_decoder_if.slave   bus
);
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    dec_state_t state_q, state_d;
    key_t       key_q, key_d;
    logic       key_valid_q, key_valid_d;
    logic       frame_err_q, frame_err_d;
    key_t       mapped;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        frame_err_d = rx_err;
        mapped      = sc_to_key(rx_byte);

        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT)
                        state_d = ST_EXT;
                    else if (rx_byte == SC_BREAK)
                        state_d = ST_BREAK;
                    else if (mapped != key_relesed)
                        key_d = mapped;
                end
                ST_EXT:
                    state_d = (rx_byte == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                ST_BREAK: begin
                    // Releasing a key that is no longer the current one is ignored.
                    if (key_q != key_relesed && rx_byte == key_to_sc(key_q))
                        key_d = key_relesed;
                    state_d = ST_IDLE;
                end
                default:
                    state_d = ST_IDLE;
            endcase
        end

        key_valid_d = (key_d != key_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= key_relesed;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.key_code  = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized self-checking bench for ps2_key_decoder against a key-event model
module tb_ps2_key_decoder;
    localparam int FILT = 8;
    localparam int TMO  = 300;
    localparam int HALF = 24;
    localparam int LAT  = FILT + 4;

    logic clk;
    logic rst_n;
    ps2_key_decoder_if ifc();

    ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    int kv_cyc = 0;
    int stop_cyc = 0;
    int model_key = 0;
    logic [7:0] sc_tab [10] = '{8'h00, 8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};
    logic [7:0] junk_tab [4] = '{8'h2A, 8'h15, 8'h4D, 8'h5A};

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifc.key_valid) begin
            kv_cnt = kv_cnt + 1;
            kv_cyc = cyc;
        end
        if (ifc.frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            wait_clks(HALF/2 - 3);
            if (glitch) begin
                ifc.ps2_clk = 1'b0;
                wait_clks(2);
                ifc.ps2_clk = 1'b1;
            end else begin
                wait_clks(2);
            end
            ifc.ps2_data = bits[i];
            wait_clks(HALF/2);
            #1 ifc.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_clks(HALF);
            #1 ifc.ps2_clk = 1'b1;
        end
        wait_clks(HALF/2);
        ifc.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch);
        logic par;
        par = ~(^b) ^ flip;
        send_bits({1'b1, par, b, 1'b0}, 11, glitch);
        wait_clks(2*HALF);
    endtask

    // Sends n bytes (parity flipped on the last one if asked) and checks the key-level outcome.
    task automatic run_seq(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit flip, input int exp_fe, input bit glitch,
                           input int new_key);
        int kv0, fe0;
        logic [7:0] bs [3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < n; i++) send_frame(bs[i], flip && (i == n-1), glitch);
        wait_clks(4);
        chk({tag, "_key"}, int'(ifc.key_code), new_key);
        chk({tag, "_kv"}, kv_cnt - kv0, (new_key != model_key) ? 1 : 0);
        chk({tag, "_fe"}, fe_cnt - fe0, exp_fe);
        model_key = new_key;
    endtask

    function automatic int after_release(input logic [7:0] sc);
        if (model_key != 0 && sc_tab[model_key] == sc) return 0;
        return model_key;
    endfunction

    initial begin
        int kv0, fe0, k, t;
        logic [7:0] sc;
        bit gl;
        rst_n = 1'b0;
        ifc.ps2_clk = 1'b1;
        ifc.ps2_data = 1'b1;
        wait_clks(5);
        chk("rst_key", int'(ifc.key_code), 0);
        chk("rst_kv", int'(ifc.key_valid), 0);
        chk("rst_fe", int'(ifc.frame_err), 0);
        rst_n = 1'b1;
        wait_clks(10);

        // Mid-frame reset, then a clean frame must decode.
        send_bits({1'b1, ~(^8'h1D), 8'h1D, 1'b0}, 5, 1'b0);
        rst_n = 1'b0;
        wait_clks(3);
        chk("mid_rst_key", int'(ifc.key_code), 0);
        chk("mid_rst_kv", int'(ifc.key_valid), 0);
        chk("mid_rst_fe", int'(ifc.frame_err), 0);
        rst_n = 1'b1;
        wait_clks(2*HALF);
        run_seq("t1_w", 1, 8'h1D, 8'h00, 8'h00, 1'b0, 0, 1'b0, 3);
        chk("t1_lat", kv_cyc - stop_cyc, LAT);
        run_seq("t2_rel", 2, 8'hF0, 8'h1D, 8'h00, 1'b0, 0, 1'b0, 0);
        run_seq("t2_w", 1, 8'h1D, 8'h00, 8'h00, 1'b0, 0, 1'b0, 3);
        chk("t2_lat", kv_cyc - stop_cyc, LAT);

        // Typematic repeats of A: one pulse only; release of a non-held key is ignored.
        kv0 = kv_cnt;
        run_seq("t3_a0", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1);
        run_seq("t3_a1", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1);
        run_seq("t3_a2", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1);
        chk("t3_kv_total", kv_cnt - kv0, 1);
        run_seq("t3_relS", 2, 8'hF0, 8'h1B, 8'h00, 1'b0, 0, 1'b0, 1);

        run_seq("t4_bad", 1, 8'h1B, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1);
        run_seq("t4_s", 1, 8'h1B, 8'h00, 8'h00, 1'b0, 0, 1'b0, 2);

        // Partial frame then silence past the timeout.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits({1'b1, ~(^8'h55), 8'h55, 1'b0}, 5, 1'b0);
        wait_clks(TMO + 100);
        chk("t5_tmo_fe", fe_cnt - fe0, 1);
        chk("t5_tmo_kv", kv_cnt - kv0, 0);
        run_seq("t5_esc", 1, 8'h76, 8'h00, 8'h00, 1'b0, 0, 1'b0, 9);

        run_seq("t6_ext", 2, 8'hE0, 8'h75, 8'h00, 1'b0, 0, 1'b1, 9);
        run_seq("t6_extrel", 3, 8'hE0, 8'hF0, 8'h75, 1'b0, 0, 1'b1, 9);
        run_seq("t6_junk", 1, 8'h2A, 8'h00, 8'h00, 1'b0, 0, 1'b1, 9);
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            wait_clks(5);
            ifc.ps2_clk = 1'b0;
            wait_clks(2);
            ifc.ps2_clk = 1'b1;
        end
        wait_clks(TMO + 20);
        chk("t6_glitch_kv", kv_cnt - kv0, 0);
        chk("t6_glitch_fe", fe_cnt - fe0, 0);
        run_seq("t6_d", 1, 8'h23, 8'h00, 8'h00, 1'b0, 0, 1'b1, 4);

        // Random key events against the event-level model.
        for (int e = 0; e < 16; e++) begin
            t  = $urandom_range(0, 5);
            gl = 1'($urandom_range(0, 1));
            k  = $urandom_range(1, 9);
            case (t)
                0: run_seq("r_press", 1, sc_tab[k], 8'h00, 8'h00, 1'b0, 0, gl, k);
                1: begin
                    sc = (model_key != 0 && $urandom_range(0, 1) == 1) ? sc_tab[model_key] : sc_tab[k];
                    run_seq("r_rel", 2, 8'hF0, sc, 8'h00, 1'b0, 0, gl, after_release(sc));
                end
                2: run_seq("r_ext", 2, 8'hE0, sc_tab[k], 8'h00, 1'b0, 0, gl, model_key);
                3: run_seq("r_extrel", 3, 8'hE0, 8'hF0, sc_tab[k], 1'b0, 0, gl, model_key);
                4: run_seq("r_junk", 1, junk_tab[k % 4], 8'h00, 8'h00, 1'b0, 0, gl, model_key);
                default: run_seq("r_bad", 1, sc_tab[k], 8'h00, 8'h00, 1'b1, 1, gl, model_key);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
